// File: rtl/serial_tx_if.sv
// serial_tx_if: bundle between the frame serializer and its neighbours.
//
// Handshake: i_run is a level request and o_tx_done is the completion strobe.
// While i_run is high the serializer loads i_data on any IDLE cycle in which
// o_tx_done is low, sends the frame, and then raises o_tx_done for exactly one
// cycle. The producer advances its word on that strobe. The serializer samples
// i_data only on the load cycle; it ignores i_data at all other times.
interface serial_tx_if;
  logic       i_run;
  logic [9:0] i_data;
  logic       o_serial;
  logic       o_busy;
  logic       o_tx_done;
  logic [9:0] o_tx_data;

  // Serializer side.
  modport slave (
    input  i_run,
    input  i_data,
    output o_serial,
    output o_busy,
    output o_tx_done,
    output o_tx_data
  );

  // Producer/consumer side.
  modport master (
    output i_run,
    output i_data,
    input  o_serial,
    input  o_busy,
    input  o_tx_done,
    input  o_tx_data
  );
endinterface

// File: rtl/serial_tx.sv
// serial_tx: serializes a 10-bit word LSB-first as a start/data/stop frame
// and pulses o_tx_done for one cycle when the frame completes.
// Optional feature macro TX_PARITY_EN adds an even-parity bit between data
// bit 9 and the stop bit.
// All outputs come from flops. Each output's next value is computed from the
// next state, so a load edge is followed directly by the first START cycle.
module serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  serial_tx_if.slave  bus,
  output logic [2:0]  o_dbg_state
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  shift_q, shift_d;
  logic [9:0]  tx_data_q, tx_data_d;
  logic [3:0]  bit_q, bit_d;
  logic [BW-1:0] baud_q, baud_d;
  logic        serial_q, serial_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        baud_wrap;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    tx_data_d = tx_data_q;
    bit_d     = bit_q;
    baud_d    = baud_q;
    done_d    = 1'b0;
    serial_d  = 1'b1;
    busy_d    = 1'b0;
    baud_wrap = (baud_q == BAUD_LAST);

    case (state_q)
      IDLE: begin
        // A load is held off during the done cycle so that the producer's
        // freshly advanced word is the one that gets latched.
        if (bus.i_run && !done_q) begin
          shift_d   = bus.i_data;
          tx_data_d = bus.i_data;
          bit_d     = 4'd0;
          baud_d    = '0;
          state_d   = START;
        end
      end
      START: begin
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_wrap) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[9:1]};
          if (bit_q == 4'd9) begin
`ifdef TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef TX_PARITY_EN
      PARITY: begin
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level for the cycle after this edge, taken from the next state.
    case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
`ifdef TX_PARITY_EN
      PARITY:  serial_d = ^tx_data_d;
`endif
      default: serial_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      tx_data_q <= '0;
      bit_q     <= '0;
      baud_q    <= '0;
      serial_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      tx_data_q <= tx_data_d;
      bit_q     <= bit_d;
      baud_q    <= baud_d;
      serial_q  <= serial_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.o_serial  = serial_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_tx_done = done_q;
  assign bus.o_tx_data = tx_data_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed bench for serial_tx at CLKS_PER_BIT=4, with a small
// count-generator model that advances on o_tx_done.
module tb_serial_tx;

  localparam int unsigned C = 4;
`ifdef TX_PARITY_EN
  localparam int unsigned NB = 13;
`else
  localparam int unsigned NB = 12;
`endif
  localparam int unsigned PERIOD = NB * C + 2;

  // Clock / reset.
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_tx_if bus ();
  logic [2:0] dbg_state;

  serial_tx #(.CLKS_PER_BIT(C)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Generator model and data source select.
  logic [9:0] gen_cnt;
  logic       gen_set;
  logic [9:0] gen_set_val;
  logic       use_gen;
  logic [9:0] direct_data;
  int         cyc = 0;
  int         done_cnt = 0;

  always @(posedge clk) begin
    if (gen_set) gen_cnt <= gen_set_val;
    else if (bus.o_tx_done) gen_cnt <= gen_cnt + 10'd1;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.o_tx_done) done_cnt <= done_cnt + 1;
  end

  assign bus.i_data = use_gen ? gen_cnt : direct_data;

  // Scoreboard.
  logic [9:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int last_start = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Checks one whole frame for the next expected word, cycle by cycle,
  // followed by the done cycle.
  task automatic expect_frame(input int max_wait, input bit chk_period,
                              input bit drop_at_stop, input bit poke_en,
                              input logic [9:0] poke_val);
    logic [9:0]  w;
    logic [12:0] bits;
    int          waited;
    if (exp_q.size() == 0) begin
      check_eq("exp_q_empty", 32'd1, 32'd0);
      return;
    end
    w = exp_q.pop_front();
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.o_busy && waited < max_wait);
    check_eq("frame_start", 32'(bus.o_busy), 32'd1);
    if (!bus.o_busy) return;
    if (chk_period) check_eq("period", 32'(cyc - last_start), 32'(PERIOD));
    last_start = cyc;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 10; i++) bits[i+1] = w[i];
`ifdef TX_PARITY_EN
    bits[11] = ^w;
`endif
    for (int j = 0; j < int'(NB * C); j++) begin
      if (j > 0) @(negedge clk);
      check_eq("serial_bit", 32'(bus.o_serial), 32'(bits[j / int'(C)]));
      check_eq("in_frame", 32'({bus.o_busy, bus.o_tx_done, bus.o_tx_data}),
               32'({1'b1, 1'b0, w}));
      if (drop_at_stop && j == int'((NB - 1) * C)) bus.i_run = 1'b0;
      if (poke_en && j == int'(5 * C)) direct_data = poke_val;
    end
    @(negedge clk);
    check_eq("done_cycle", 32'({bus.o_tx_done, bus.o_busy, bus.o_serial}), 32'(3'b101));
  endtask

  // Line must stay idle for n cycles.
  task automatic expect_idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_eq("idle", 32'({bus.o_busy, bus.o_serial, bus.o_tx_done}), 32'(3'b010));
    end
  endtask

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  int d0;

  initial begin
    rst = 1'b1;
    bus.i_run = 1'b0;
    use_gen = 1'b1;
    direct_data = '0;
    gen_set = 1'b1;
    gen_set_val = 10'd0;
    repeat (3) @(negedge clk);
    gen_set = 1'b0;

    // Reset state.
    check_eq("rst_serial", 32'(bus.o_serial), 32'd1);
    check_eq("rst_busy", 32'(bus.o_busy), 32'd0);
    check_eq("rst_done", 32'(bus.o_tx_done), 32'd0);
    check_eq("rst_tx_data", 32'(bus.o_tx_data), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);

    // Generator attached: words 0 then 1 back-to-back; drop run in STOP.
    bus.i_run = 1'b1;
    rst = 1'b0;
    exp_q.push_back(10'd0);
    expect_frame(1, 1'b0, 1'b0, 1'b0, 10'd0);
    exp_q.push_back(10'd1);
    expect_frame(3, 1'b1, 1'b1, 1'b0, 10'd0);
    expect_idle(20);
    check_eq("done_count_a", 32'(done_cnt), 32'd2);
    bus.i_run = 1'b1;
    exp_q.push_back(10'd2);
    expect_frame(1, 1'b0, 1'b1, 1'b0, 10'd0);
    expect_idle(5);

    // Direct word 0x2A5; i_data changed mid-frame must not disturb it.
    use_gen = 1'b0;
    direct_data = 10'h2A5;
    bus.i_run = 1'b1;
    exp_q.push_back(10'h2A5);
    expect_frame(1, 1'b0, 1'b0, 1'b1, 10'h3FF);
    exp_q.push_back(10'h3FF);
    expect_frame(3, 1'b1, 1'b1, 1'b0, 10'd0);
    expect_idle(5);

    // Generator wrap 1022, 1023, 0.
    gen_set = 1'b1;
    gen_set_val = 10'd1022;
    @(negedge clk);
    gen_set = 1'b0;
    use_gen = 1'b1;
    d0 = done_cnt;
    bus.i_run = 1'b1;
    exp_q.push_back(10'd1022);
    expect_frame(1, 1'b0, 1'b0, 1'b0, 10'd0);
    exp_q.push_back(10'd1023);
    expect_frame(3, 1'b1, 1'b0, 1'b0, 10'd0);
    exp_q.push_back(10'd0);
    expect_frame(3, 1'b1, 1'b1, 1'b0, 10'd0);
    expect_idle(10);
    check_eq("done_count_wrap", 32'(done_cnt - d0), 32'd3);

    // Reset in the middle of data bit 5 of 0x155 (bit 5 is 0).
    use_gen = 1'b0;
    direct_data = 10'h155;
    bus.i_run = 1'b1;
    @(negedge clk);
    check_eq("rst_test_start", 32'({bus.o_busy, bus.o_serial}), 32'(2'b10));
    repeat (C + 5 * C + 1) @(negedge clk);
    check_eq("bit5_level", 32'({bus.o_busy, bus.o_serial}), 32'(2'b10));
    d0 = done_cnt;
    rst = 1'b1;
    direct_data = 10'h0F0;
    @(negedge clk);
    check_eq("abort_outputs", 32'({bus.o_serial, bus.o_busy, bus.o_tx_done}), 32'(3'b100));
    rst = 1'b0;
    exp_q.push_back(10'h0F0);
    expect_frame(1, 1'b0, 1'b1, 1'b0, 10'd0);
    expect_idle(5);
    check_eq("done_after_abort", 32'(done_cnt - d0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
# serial_tx

Frame serializer sitting directly downstream of the 10-bit count generator. It latches one 10-bit word, sends it LSB-first on a single-wire line as a start/data/stop frame, and pulses a one-cycle completion strobe. That strobe drives the generator's enable, so the generator advances exactly once per completed frame. The serial line feeds the downstream pattern detector.

## Interface
- CLKS_PER_BIT, default 4: clock cycles each bit is held on the line; legal range 1..65535.
- i_clk  input  1  single clock; all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_run  input  1  level; while high, frames are sent back-to-back.
- i_data  input  10  word to send; connects to generator count.
- o_serial  output  1  serial line; idle high.
- o_busy  output  1  high while a frame is in progress (state != IDLE).
- o_tx_done  output  1  one-cycle completion pulse; connects to generator enable.
- o_tx_data  output  10  copy of the word in flight, for scoreboarding.

## Operation
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE:
  - o_serial=1.
  - Load occurs when i_run=1 and o_tx_done=0: shift register and o_tx_data <= i_data, bit counter <= 0, baud counter <= 0, next state START.
- START: o_serial=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - o_serial = shift_reg[0], each bit held CLKS_PER_BIT cycles.
  - Shift right after each bit.
  - After bit 9 completes: PARITY if enabled, else STOP.
- PARITY: o_serial = XOR of o_tx_data (even parity) for CLKS_PER_BIT cycles, then STOP.
- STOP: o_serial=1 for CLKS_PER_BIT cycles. Then IDLE, with o_tx_done=1 on the first IDLE cycle.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT)+1.
  - Counts 0..CLKS_PER_BIT-1 and wraps.
  - Bit advances on the wrap.
  - With CLKS_PER_BIT=1 every cycle is one bit.
- Load blocked while o_tx_done=1, so the generator's incremented value is sampled rather than the stale one.
- i_run falling mid-frame: the current frame completes and o_tx_done still pulses; no new load.
- i_data changes mid-frame: ignored; only the load-cycle value is sent.
- Reset mid-frame: frame aborted, no done pulse, next frame starts from a fresh load.
- Generator wrap 1023->0 is transparent; the serializer sends whatever it latches.

## Timing
- Reset values: o_serial=1, o_busy=0, o_tx_done=0, o_tx_data=0, state IDLE.
- All outputs registered; no combinational path from inputs to outputs.
- Frame length: 12*CLKS_PER_BIT cycles, or 13*CLKS_PER_BIT with parity.
- Load edge to first START cycle: 1 cycle.
- o_busy: high from the first START cycle through the last STOP cycle.
- o_tx_done: high exactly 1 cycle, immediately after the last STOP cycle.
- Back-to-back sequence: done cycle (generator increments at its end), then one IDLE load cycle, then START.
  - Start-to-start period = 12*CLKS_PER_BIT+2 (50 at default), or 13*CLKS_PER_BIT+2 with parity.
- First frame after reset with i_run held high: load in the first post-reset cycle; word 0 is sent.

## Configuration
- TX_PARITY_EN:
  - Defined: PARITY state compiled in; even-parity bit inserted between data bit 9 and stop; frame is 13 bits.
  - Undefined: no PARITY state and no parity logic; frame is 12 bits; DATA goes directly to STOP.

## Test plan
- Reset then i_run=1, CLKS_PER_BIT=4, no parity, generator attached:
  - o_serial low for cycles 2-5 (start).
  - Ten data bits of 0 across the next 40 cycles, then 4 stop cycles high.
  - o_tx_done pulses at cycle 50; the second frame carries 1.
- Direct i_data=10'h2A5 (no generator):
  - Line bits after start = 1,0,1,0,0,1,0,1,0,1, each 4 cycles.
  - o_tx_data=0x2A5 throughout the frame.
- TX_PARITY_EN defined, i_data=10'h2A5:
  - Parity bit = 1; frame 52 cycles; start-to-start period 54.
  - With i_data=0: parity bit = 0.
- Generator preset to 1022, run 3 frames: words sent 1022, 1023, 0; exactly 3 done pulses.
- i_rst asserted mid-DATA (bit 5):
  - Next cycle o_serial=1, o_busy=0, no done pulse.
  - After release, a fresh frame starts with the current i_data.
- i_run dropped during STOP of frame N:
  - Done pulses once; line stays high; no further START.
  - Re-raising i_run loads the incremented word on the next IDLE cycle.
